// File: rtl/jamma_pkg.sv
// Shared definitions for the JAMMA joystick scanner: bus bit positions,
// scan state encoding, idle word and the SOCD cleaning helper.
package jamma_pkg;

  localparam int JB_UP    = 0;
  localparam int JB_DOWN  = 1;
  localparam int JB_LEFT  = 2;
  localparam int JB_RIGHT = 3;
  localparam int JB_FIRE1 = 4;
  localparam int JB_FIRE2 = 5;
  localparam int JB_FIRE3 = 6;
  localparam int JB_START = 7;

  localparam logic [7:0] JOY_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    P1_SETTLE = 2'd0,
    SAMPLE_P1 = 2'd1,
    P2_SETTLE = 2'd2,
    SAMPLE_P2 = 2'd3
  } scan_state_t;

  // Opposing directions pressed together (both low) are both released.
  function automatic logic [7:0] socd_clean(input logic [7:0] w);
    logic [7:0] r;
    r = w;
    if (!w[JB_UP] && !w[JB_DOWN]) begin
      r[JB_UP]   = 1'b1;
      r[JB_DOWN] = 1'b1;
    end
    if (!w[JB_LEFT] && !w[JB_RIGHT]) begin
      r[JB_LEFT]  = 1'b1;
      r[JB_RIGHT] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/jamma_debounce.sv
// Whole-word debouncer: the output only takes a new value once the same
// word has been seen on DEBOUNCE_SAMPLES consecutive sample strobes.
module jamma_debounce #(
  parameter int W                = 8,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sample_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int CW = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SAMPLES - 1);

  logic [W-1:0]  shadow_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [W-1:0]  dout_reg;

  // Any bit difference restarts the run; a matching sample extends it up to CNT_MAX.
  always_comb begin
    count_next = count_reg;
    if (din == shadow_reg) begin
      if (count_reg != CNT_MAX) count_next = count_reg + CW'(1);
    end else begin
      count_next = '0;
    end
  end

  // Update shadow and run length on each strobe; commit the word when the run is long enough.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_reg <= '1;
      count_reg  <= '0;
      dout_reg   <= '1;
    end else if (sample_en) begin
      shadow_reg <= din;
      count_reg  <= count_next;
      if (count_next == CNT_MAX) dout_reg <= din;
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/jamma_joy_scanner.sv
// Scans the shared JAMMA joystick bus for player 1 and player 2 via JSELECT,
// waiting a settle window after each select change before sampling, and
// debounces both players and the coin inputs.
// Optional build macro JOY_SOCD_EN: enables the SOCD cleaner on JOY1/JOY2.
module jamma_joy_scanner
  import jamma_pkg::*;
#(
  parameter int SETTLE_CYCLES    = 16,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] JJOY,
  input  logic [5:0] LOCAL_JOY,
  input  logic [1:0] JCOIN,
  output logic       JSELECT,
  output logic [7:0] JOY1,
  output logic [7:0] JOY2,
  output logic [1:0] COIN,
  output logic       SCAN_TICK
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  scan_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             jselect_reg;
  logic             scan_tick_reg;
  logic             sample_p1, sample_p2;
  logic [7:0]       p1_word;
  logic [7:0]       p1_db, p2_db;
  logic [1:0]       coin_db;

  // Scan state, settle counter, registered select decode and end-of-scan pulse.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_reg     <= P1_SETTLE;
      cnt_reg       <= CNT_RELOAD;
      jselect_reg   <= 1'b0;
      scan_tick_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      jselect_reg   <= (state_next == P2_SETTLE) || (state_next == SAMPLE_P2);
      scan_tick_reg <= (state_reg == SAMPLE_P2);
    end
  end

  // Next-state: count down each settle window, sample for one cycle, then reload.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      P1_SETTLE: begin
        if (cnt_reg == '0) state_next = SAMPLE_P1;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      SAMPLE_P1: begin
        cnt_next   = CNT_RELOAD;
        state_next = P2_SETTLE;
      end
      P2_SETTLE: begin
        if (cnt_reg == '0) state_next = SAMPLE_P2;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      SAMPLE_P2: begin
        cnt_next   = CNT_RELOAD;
        state_next = P1_SETTLE;
      end
      default: begin
        state_next = P1_SETTLE;
        cnt_next   = CNT_RELOAD;
      end
    endcase
  end

  assign sample_p1 = (state_reg == SAMPLE_P1);
  assign sample_p2 = (state_reg == SAMPLE_P2);

  // The onboard joystick shares the P1 direction and fire bits.
  assign p1_word = {JJOY[7:6], JJOY[5:0] & LOCAL_JOY};

  jamma_debounce #(.W(8), .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_db_p1 (
    .clk       (CLK),
    .reset_n   (RESET_N),
    .sample_en (sample_p1),
    .din       (p1_word),
    .dout      (p1_db)
  );

  jamma_debounce #(.W(8), .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_db_p2 (
    .clk       (CLK),
    .reset_n   (RESET_N),
    .sample_en (sample_p2),
    .din       (JJOY),
    .dout      (p2_db)
  );

  // Coins are not multiplexed, so they are sampled in both sample slots.
  jamma_debounce #(.W(2), .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_db_coin (
    .clk       (CLK),
    .reset_n   (RESET_N),
    .sample_en (sample_p1 | sample_p2),
    .din       (JCOIN),
    .dout      (coin_db)
  );

  // The cleaner is pure logic on the registered debounced words.
`ifdef JOY_SOCD_EN
  assign JOY1 = socd_clean(p1_db);
  assign JOY2 = socd_clean(p2_db);
`else
  assign JOY1 = p1_db;
  assign JOY2 = p2_db;
`endif

  assign COIN      = coin_db;
  assign JSELECT   = jselect_reg;
  assign SCAN_TICK = scan_tick_reg;

endmodule

// File: tb/tb_jamma_joy_scanner.sv
// Self-checking bench for jamma_joy_scanner: directed scenarios plus
// randomized bus/coin activity against a cycle-indexed reference model.
module tb_jamma_joy_scanner;

  localparam int SETTLE = 16;
  localparam int NDB    = 4;
  localparam int PERIOD = 2 * (SETTLE + 1);

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] jjoy = 8'hFF;
  logic [5:0] local_joy = 6'h3F;
  logic [1:0] jcoin = 2'b11;
  logic       jselect;
  logic [7:0] joy1, joy2;
  logic [1:0] coin;
  logic       scan_tick;

  // Words the two players present when selected.
  logic [7:0] p1 = 8'hFF;
  logic [7:0] p2 = 8'hFF;

  // Reference model state.
  int         t;
  int         scans;
  logic [7:0] hq0[$], hq1[$], hq2[$];
  logic [7:0] exp_joy1, exp_joy2, exp_coin;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  jamma_joy_scanner #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SAMPLES(NDB)) dut (
    .CLK       (clk),
    .RESET_N   (reset_n),
    .JJOY      (jjoy),
    .LOCAL_JOY (local_joy),
    .JCOIN     (jcoin),
    .JSELECT   (jselect),
    .JOY1      (joy1),
    .JOY2      (joy2),
    .COIN      (coin),
    .SCAN_TICK (scan_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, t, got, exp);
    end
  endtask

  function automatic logic [7:0] model_socd(input logic [7:0] w);
    logic [7:0] r;
    r = w;
`ifdef JOY_SOCD_EN
    if (w[1:0] == 2'b00) r[1:0] = 2'b11;
    if (w[3:2] == 2'b00) r[3:2] = 2'b11;
`endif
    return r;
  endfunction

  // A channel's output follows the input once the last NDB samples agree.
  // Reset leaves the history holding one idle word.
  task automatic model_sample(input int ch, input logic [7:0] s);
    logic [7:0] h[$];
    bit same;
    case (ch)
      0: h = hq0;
      1: h = hq1;
      default: h = hq2;
    endcase
    h.push_back(s);
    if (h.size() > NDB) void'(h.pop_front());
    same = (h.size() == NDB);
    foreach (h[i]) if (h[i] != s) same = 0;
    case (ch)
      0: begin hq0 = h; if (same) exp_joy1 = s; end
      1: begin hq1 = h; if (same) exp_joy2 = s; end
      default: begin hq2 = h; if (same) exp_coin = s; end
    endcase
  endtask

  task automatic model_reset();
    t = 0;
    hq0 = {8'hFF};
    hq1 = {8'hFF};
    hq2 = {8'hFF};
    exp_joy1 = 8'hFF;
    exp_joy2 = 8'hFF;
    exp_coin = 8'hFF;
  endtask

  // Called at a falling edge; leaves the bench at the falling edge of cycle 0.
  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Check the current cycle, drive the bus for it, and advance the model one edge.
  task automatic cycle();
    int ph;
    ph = t % PERIOD;
    check("jselect", 32'(jselect), 32'(ph > SETTLE));
    check("scan_tick", 32'(scan_tick), 32'(t >= PERIOD && ph == 0));
    check("joy1", 32'(joy1), 32'(model_socd(exp_joy1)));
    check("joy2", 32'(joy2), 32'(model_socd(exp_joy2)));
    check("coin", 32'(coin), 32'(exp_coin[1:0]));
    if (t > 0 && ph == 0) begin
      scans++;
      $display("scan %0d cycle %0d: joy1=%h joy2=%h coin=%b", scans, t, joy1, joy2, coin);
    end
    jjoy = (ph > SETTLE) ? p2 : p1;
    @(posedge clk);
    if (ph == SETTLE) begin
      model_sample(0, {jjoy[7:6], jjoy[5:0] & local_joy});
      model_sample(2, {6'h3F, jcoin});
    end
    if (ph == PERIOD - 1) begin
      model_sample(1, jjoy);
      model_sample(2, {6'h3F, jcoin});
    end
    t++;
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (t < target) cycle();
  endtask

  initial begin
    logic [7:0] pool[4];
    int hold;
    pool = '{8'hFF, 8'hFE, 8'hFC, 8'hEF};
    scans = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Idle bus: select pattern, tick cadence, outputs stay idle.
    do_reset();
    check("rst_jselect", 32'(jselect), 32'(0));
    check("rst_joy1", 32'(joy1), 32'hFF);
    check("rst_tick", 32'(scan_tick), 32'(0));
    run_to(34);
    check("idle_tick34", 32'(scan_tick), 32'(1));
    run_to(69);
    check("idle_joy2", 32'(joy2), 32'hFF);

    // P1 up only: fourth P1 sample at 118 commits at 119.
    p1 = 8'hFE; p2 = 8'hFF;
    do_reset();
    run_to(118);
    check("p1up_118", 32'(joy1), 32'hFF);
    run_to(119);
    check("p1up_119", 32'(joy1), 32'hFE);
    check("p1up_joy2", 32'(joy2), 32'hFF);

    // Fire1 glitch on the first sample: bit 4 never drops, up commits one period late.
    p1 = 8'hEE;
    do_reset();
    run_to(20);
    p1 = 8'hFE;
    run_to(152);
    check("glitch_152", 32'(joy1), 32'hFF);
    run_to(153);
    check("glitch_153", 32'(joy1), 32'hFE);

    // Onboard joystick merged into P1.
    p1 = 8'hFF; local_joy = 6'h3B;
    do_reset();
    run_to(119);
    check("local_joy1", 32'(joy1), 32'hFB);
    check("local_joy2", 32'(joy2), 32'hFF);
    local_joy = 6'h3F;

    // Reset during P2 settle restarts the scan from P1.
    do_reset();
    run_to(25);
    check("mid_sel25", 32'(jselect), 32'(1));
    do_reset();
    check("mid_sel0", 32'(jselect), 32'(0));
    run_to(17);
    check("mid_sel17", 32'(jselect), 32'(1));

    // P2 up+down together.
    p2 = 8'hFC;
    do_reset();
    run_to(137);
`ifdef JOY_SOCD_EN
    check("socd_joy2", 32'(joy2), 32'hFF);
`else
    check("socd_joy2", 32'(joy2), 32'hFC);
`endif

    // Randomized activity with occasional resets.
    for (int ep = 0; ep < 60; ep++) begin
      if ($urandom_range(0, 7) == 0) do_reset();
      p1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 3)];
      p2 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 3)];
      local_joy = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'h3F;
      jcoin = 2'($urandom);
      hold = $urandom_range(10, 160);
      run_to(t + hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
